// File: rtl/multi_channel_timer_if.sv
// Register bus between the management SoC and the timer block.
// One request per valid/ready pair; wstrb == 0 marks a read.
interface multi_channel_timer_if #(
  parameter int ADR_BITS = 32
);
  logic                valid;
  logic [3:0]          wstrb;
  logic [31:0]         wdata;
  logic [ADR_BITS-1:0] wbs_adr_i;
  logic                ready;
  logic [31:0]         rdata;

  modport master (
    output valid, wstrb, wdata, wbs_adr_i,
    input  ready, rdata
  );

  modport slave (
    input  valid, wstrb, wdata, wbs_adr_i,
    output ready, rdata
  );
endinterface

// File: rtl/multi_channel_timer.sv
// NUM_CH independent prescaled up/down counters with limit compare, one-shot or
// auto-reload, sticky match flags and an aggregated interrupt, behind a register bus.
module multi_channel_timer #(
  parameter int NUM_CH     = 4,
  parameter int BITS       = 32,
  parameter int PRESC_BITS = 8,
  parameter int ADR_BITS   = 32
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  multi_channel_timer_if.slave   bus,
  output logic [NUM_CH*BITS-1:0] count_o,
  output logic [NUM_CH-1:0]      match_o,
  output logic                   irq
);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_LIMIT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic [NUM_CH-1:0][BITS-1:0]       count_q, count_d;
  logic [NUM_CH-1:0][BITS-1:0]       limit_q, limit_d;
  logic [NUM_CH-1:0][PRESC_BITS-1:0] presc_q, presc_d;
  logic [NUM_CH-1:0][PRESC_BITS-1:0] pcnt_q, pcnt_d;
  logic [NUM_CH-1:0] en_q, en_d, dir_q, dir_d, oneshot_q, oneshot_d;
  logic [NUM_CH-1:0] irq_en_q, irq_en_d, match_q, match_d;
  logic [NUM_CH-1:0] match_o_q, match_o_d;
  logic              ready_q, ready_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              access, is_write;
  logic [2:0]        sel_ch;
  logic [1:0]        sel_reg;
  logic [31:0]       wmask, rd_val, wr_val;
  logic [NUM_CH-1:0] hit_ctrl, hit_count, hit_limit, hit_status;
  logic [NUM_CH-1:0] tick, term;
  logic              unused_adr;

  assign access   = bus.valid & ~ready_q;
  assign is_write = access & (|bus.wstrb);
  assign sel_ch   = bus.wbs_adr_i[6:4];
  assign sel_reg  = bus.wbs_adr_i[3:2];
  assign wmask    = {{8{bus.wstrb[3]}}, {8{bus.wstrb[2]}}, {8{bus.wstrb[1]}}, {8{bus.wstrb[0]}}};
  assign unused_adr = ^{bus.wbs_adr_i[1:0], bus.wbs_adr_i[ADR_BITS-1:7]};

  always_comb begin
    rd_val = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (sel_ch == 3'(n)) begin
        case (sel_reg)
          REG_CTRL: begin
            rd_val[0]              = en_q[n];
            rd_val[1]              = dir_q[n];
            rd_val[2]              = oneshot_q[n];
            rd_val[3]              = irq_en_q[n];
            rd_val[8 +: PRESC_BITS] = presc_q[n];
          end
          REG_COUNT:  rd_val[BITS-1:0] = count_q[n];
          REG_LIMIT:  rd_val[BITS-1:0] = limit_q[n];
          default:    rd_val[0]        = match_q[n];
        endcase
      end
    end
  end

  // Partial writes merge into the current register image, so untouched bytes survive.
  assign wr_val = (rd_val & ~wmask) | (bus.wdata & wmask);

  always_comb begin
    hit_ctrl   = '0;
    hit_count  = '0;
    hit_limit  = '0;
    hit_status = '0;
    tick       = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (is_write && sel_ch == 3'(n)) begin
        hit_ctrl[n]   = (sel_reg == REG_CTRL);
        hit_count[n]  = (sel_reg == REG_COUNT);
        hit_limit[n]  = (sel_reg == REG_LIMIT);
        hit_status[n] = (sel_reg == REG_STATUS);
      end
      // A COUNT write or a disabling CTRL write swallows this cycle's tick.
      tick[n] = en_q[n] && (pcnt_q[n] == presc_q[n]) &&
                !hit_count[n] && !(hit_ctrl[n] && !wr_val[0]);
    end
  end

  always_comb begin
    count_d   = count_q;
    limit_d   = limit_q;
    presc_d   = presc_q;
    pcnt_d    = pcnt_q;
    en_d      = en_q;
    dir_d     = dir_q;
    oneshot_d = oneshot_q;
    irq_en_d  = irq_en_q;
    match_d   = match_q;
    term      = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (!en_q[n] || hit_count[n] || (hit_ctrl[n] && !wr_val[0])) begin
        pcnt_d[n] = '0;
      end else if (pcnt_q[n] == presc_q[n]) begin
        pcnt_d[n] = '0;
      end else begin
        pcnt_d[n] = pcnt_q[n] + PRESC_BITS'(1);
      end

      if (tick[n]) begin
        if (!dir_q[n]) begin
          if (count_q[n] == limit_q[n]) begin
            term[n] = 1'b1;
            if (oneshot_q[n]) en_d[n] = 1'b0;
            else              count_d[n] = '0;
          end else begin
            count_d[n] = count_q[n] + BITS'(1);
          end
        end else begin
          if (count_q[n] == '0) begin
            term[n] = 1'b1;
            if (oneshot_q[n]) en_d[n] = 1'b0;
            else              count_d[n] = limit_q[n];
          end else begin
            count_d[n] = count_q[n] - BITS'(1);
          end
        end
      end

      if (hit_ctrl[n]) begin
        en_d[n]      = wr_val[0];
        dir_d[n]     = wr_val[1];
        oneshot_d[n] = wr_val[2];
        irq_en_d[n]  = wr_val[3];
        presc_d[n]   = wr_val[8 +: PRESC_BITS];
      end
      if (hit_count[n]) count_d[n] = wr_val[BITS-1:0];
      if (hit_limit[n]) limit_d[n] = wr_val[BITS-1:0];
      if (hit_status[n] && bus.wstrb[0] && bus.wdata[0]) match_d[n] = 1'b0;
      if (term[n]) match_d[n] = 1'b1;
    end
  end

  assign match_o_d = term;
  assign ready_d   = access;
  assign rdata_d   = access ? rd_val : rdata_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      count_q   <= '0;
      limit_q   <= '1;
      presc_q   <= '0;
      pcnt_q    <= '0;
      en_q      <= '0;
      dir_q     <= '0;
      oneshot_q <= '0;
      irq_en_q  <= '0;
      match_q   <= '0;
      match_o_q <= '0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      count_q   <= count_d;
      limit_q   <= limit_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      en_q      <= en_d;
      dir_q     <= dir_d;
      oneshot_q <= oneshot_d;
      irq_en_q  <= irq_en_d;
      match_q   <= match_d;
      match_o_q <= match_o_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
    end
  end

  assign count_o   = count_q;
  assign match_o   = match_o_q;
  assign irq       = |(match_q & irq_en_q);
  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_multi_channel_timer.sv
// Directed bench for multi_channel_timer: bus reads/writes, counting modes,
// sticky match / irq, byte writes, out-of-range channels and mid-run reset.
module tb_multi_channel_timer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [127:0] count_o;
  logic [3:0]  match_o;
  logic        irq;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] rd;

  multi_channel_timer_if #(.ADR_BITS(32)) bus_if ();

  multi_channel_timer #(.NUM_CH(4), .BITS(32), .PRESC_BITS(8), .ADR_BITS(32)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus_if),
    .count_o  (count_o),
    .match_o  (match_o),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the access edge is two posedges later, return at the negedge after it.
  task automatic bus_acc(input logic [2:0] ch, input logic [1:0] rg, input logic [3:0] strb,
                         input logic [31:0] data, output logic [31:0] rdv);
    @(negedge clk);
    chk("ready_idle", 32'(bus_if.ready), 32'd0);
    bus_if.valid     = 1'b1;
    bus_if.wstrb     = strb;
    bus_if.wdata     = data;
    bus_if.wbs_adr_i = {25'd0, ch, rg, 2'b00};
    @(negedge clk);
    chk("ready_ack", 32'(bus_if.ready), 32'd1);
    rdv = bus_if.rdata;
    bus_if.valid = 1'b0;
    bus_if.wstrb = 4'h0;
  endtask

  initial begin
    bus_if.valid     = 1'b0;
    bus_if.wstrb     = 4'h0;
    bus_if.wdata     = 32'h0;
    bus_if.wbs_adr_i = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst_ready", 32'(bus_if.ready), 32'd0);
    chk("rst_rdata", bus_if.rdata, 32'd0);
    chk("rst_match", 32'(match_o), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_count1", count_o[63:32], 32'd0);

    bus_acc(3'd0, 2'd0, 4'h0, 32'h0, rd); chk("ch0_ctrl", rd, 32'h0);
    bus_acc(3'd0, 2'd1, 4'h0, 32'h0, rd); chk("ch0_count", rd, 32'h0);
    bus_acc(3'd0, 2'd2, 4'h0, 32'h0, rd); chk("ch0_limit", rd, 32'hFFFF_FFFF);
    bus_acc(3'd0, 2'd3, 4'h0, 32'h0, rd); chk("ch0_status", rd, 32'h0);

    // valid held high: ready on alternate cycles
    @(negedge clk);
    bus_if.valid = 1'b1;
    bus_if.wbs_adr_i = 32'h8;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ready_alt", 32'(bus_if.ready), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    bus_if.valid = 1'b0;

    // ch1 up, limit 3, auto-reload, presc 0
    bus_acc(3'd1, 2'd2, 4'hF, 32'd3, rd);
    bus_acc(3'd1, 2'd0, 4'hF, 32'h1, rd);
    chk("ch1_cnt0", count_o[63:32], 32'd0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("ch1_cnt", count_o[63:32], 32'(i % 4));
      chk("ch1_match", 32'(match_o[1]), (i % 4 == 0) ? 32'd1 : 32'd0);
    end
    bus_acc(3'd1, 2'd3, 4'h0, 32'h0, rd); chk("ch1_status", rd, 32'h1);

    // ch2 down, oneshot, presc 2, from 5
    bus_acc(3'd2, 2'd2, 4'hF, 32'd5, rd);
    bus_acc(3'd2, 2'd1, 4'hF, 32'd5, rd);
    bus_acc(3'd2, 2'd0, 4'hF, 32'h0207, rd);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk("ch2_cnt", count_o[95:64], (k < 15) ? 32'(5 - k / 3) : 32'd0);
      chk("ch2_match", 32'(match_o[2]), (k == 18) ? 32'd1 : 32'd0);
    end
    bus_acc(3'd2, 2'd0, 4'h0, 32'h0, rd); chk("ch2_ctrl", rd, 32'h0206);
    bus_acc(3'd2, 2'd1, 4'h0, 32'h0, rd); chk("ch2_count", rd, 32'h0);
    bus_acc(3'd2, 2'd3, 4'h0, 32'h0, rd); chk("ch2_status", rd, 32'h1);

    // ch0 irq, W1C collision with terminal event
    bus_acc(3'd0, 2'd2, 4'hF, 32'd3, rd);
    bus_acc(3'd0, 2'd0, 4'hF, 32'h9, rd);
    chk("ch0_irq_pre", 32'(irq), 32'd0);
    repeat (4) @(negedge clk);
    chk("ch0_irq_set", 32'(irq), 32'd1);
    chk("ch0_match_p", 32'(match_o[0]), 32'd1);
    repeat (2) @(negedge clk);
    bus_acc(3'd0, 2'd3, 4'h1, 32'h1, rd);
    chk("ch0_match_col", 32'(match_o[0]), 32'd1);
    chk("ch0_irq_col", 32'(irq), 32'd1);
    bus_acc(3'd0, 2'd3, 4'h0, 32'h0, rd); chk("ch0_stat_col", rd, 32'h1);
    @(negedge clk);
    bus_acc(3'd0, 2'd3, 4'h1, 32'h1, rd);
    chk("ch0_irq_clr", 32'(irq), 32'd0);
    bus_acc(3'd0, 2'd3, 4'h0, 32'h0, rd); chk("ch0_stat_clr", rd, 32'h0);
    bus_acc(3'd0, 2'd0, 4'hF, 32'h0, rd);

    // ch3 byte write coincident with a tick
    bus_acc(3'd3, 2'd1, 4'hF, 32'h1234_5678, rd);
    bus_acc(3'd3, 2'd0, 4'hF, 32'h1, rd);
    bus_acc(3'd3, 2'd1, 4'h2, 32'h0000_AB00, rd);
    chk("ch3_pre_rd", rd, 32'h1234_5679);
    chk("ch3_bytewr", count_o[127:96], 32'h1234_AB79);
    @(negedge clk);
    chk("ch3_next", count_o[127:96], 32'h1234_AB7A);
    bus_acc(3'd3, 2'd0, 4'hF, 32'h0, rd);
    chk("ch3_stop", count_o[127:96], 32'h1234_AB7B);
    @(negedge clk);
    chk("ch3_held", count_o[127:96], 32'h1234_AB7B);

    // channel 7 does not exist
    bus_acc(3'd7, 2'd0, 4'hF, 32'hFFFF_FFFF, rd);
    bus_acc(3'd7, 2'd1, 4'hF, 32'hFFFF_FFFF, rd);
    bus_acc(3'd7, 2'd0, 4'h0, 32'h0, rd); chk("ch7_ctrl", rd, 32'h0);
    bus_acc(3'd7, 2'd1, 4'h0, 32'h0, rd); chk("ch7_count", rd, 32'h0);
    chk("ch7_ch3_kept", count_o[127:96], 32'h1234_AB7B);
    chk("ch7_ch2_kept", count_o[95:64], 32'h0);
    chk("ch7_irq", 32'(irq), 32'd0);

    // reset mid-run with a pending access
    @(negedge clk);
    rst = 1'b1;
    bus_if.valid = 1'b1;
    bus_if.wstrb = 4'h0;
    bus_if.wbs_adr_i = {25'd0, 3'd1, 2'd2, 2'b00};
    @(negedge clk);
    chk("mrst_ready", 32'(bus_if.ready), 32'd0);
    chk("mrst_cnt1", count_o[63:32], 32'd0);
    chk("mrst_cnt3", count_o[127:96], 32'd0);
    chk("mrst_match", 32'(match_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("retry_ready", 32'(bus_if.ready), 32'd1);
    chk("retry_rdata", bus_if.rdata, 32'hFFFF_FFFF);
    bus_if.valid = 1'b0;
    bus_acc(3'd1, 2'd0, 4'h0, 32'h0, rd); chk("mrst_ctrl1", rd, 32'h0);
    chk("mrst_cnt1_hold", count_o[63:32], 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multi_channel_timer.md
Name: multi_channel_timer

Overview:
- Parametrised successor to the single free-running counter. Provides NUM_CH independent counters, each with its own enable, direction, limit, prescaler, one-shot/auto-reload mode and sticky match flag.
- Controlled by the management SoC through the same valid/ready/wstrb register bus used by user-project slaves.
- Drives per-channel count values and match pulses toward the GPIO/LA side, plus a single aggregated interrupt.

Parameters:
- NUM_CH, 4, number of channels (1..8).
- BITS, 32, counter width per channel (8..32).
- PRESC_BITS, 8, width of the per-channel prescaler field/counter (1..16).
- ADR_BITS, 32, width of the bus address input.

Ports:
- wb_clk_i  input  1  clock for all logic.
- wb_rst_i  input  1  synchronous active-high reset.
- valid  input  1  bus request strobe.
- wstrb  input  4  byte write strobes; 0000 = read.
- wdata  input  32  write data.
- wbs_adr_i  input  ADR_BITS  byte address.
- ready  output  1  one-cycle acknowledge.
- rdata  output  32  read data, valid while ready=1.
- count_o  output  NUM_CH*BITS  live count values, channel n at [n*BITS +: BITS].
- match_o  output  NUM_CH  one-cycle pulse per channel on terminal event.
- irq  output  1  OR over channels of (STATUS.match & CTRL.irq_en).

Behaviour:
- Single clock wb_clk_i. Reset wb_rst_i is synchronous, active-high.
- Reset values:
  - count = 0; LIMIT = all ones; CTRL = 0; STATUS = 0; prescaler counters = 0.
  - ready = 0; rdata = 0; match_o = 0; irq = 0.
- Address decode:
  - wbs_adr_i[1:0] ignored.
  - [3:2] selects the register: 0 CTRL, 1 COUNT, 2 LIMIT, 3 STATUS.
  - [6:4] selects the channel.
  - Channel index ≥ NUM_CH: reads return 0, writes are ignored, ready is still given.
- CTRL fields:
  - [0] en
  - [1] dir (0 = up, 1 = down)
  - [2] oneshot
  - [3] irq_en
  - [8 +: PRESC_BITS] presc
  - Other bits read 0.
- STATUS: [0] match (sticky), write-1-to-clear. Other bits read 0.
- Register widths: COUNT and LIMIT are BITS wide, zero-extended on read. Write bits above BITS are dropped.
- Handshake:
  - When valid=1 and ready=0, the next edge sets ready=1 for exactly one cycle and captures rdata from pre-edge register contents.
  - A write applies at that same edge, byte-masked by wstrb; unselected bytes are unchanged.
  - valid held high yields ready pulses on alternate cycles (one access per 2 cycles).
  - When ready=0, rdata holds its last value.
- Prescaler:
  - While en=1, the prescaler counts 0..presc.
  - A tick occurs in the cycle where the prescaler equals presc; the prescaler then returns to 0.
  - presc=0 gives a tick every cycle.
  - en=0 holds the prescaler at 0.
- Count on tick, up direction:
  - count == LIMIT: terminal event. Auto-reload sets count to 0; oneshot holds count and clears en.
  - Otherwise count increments by 1.
- Count on tick, down direction:
  - count == 0: terminal event. Auto-reload sets count to LIMIT; oneshot holds 0 and clears en.
  - Otherwise count decrements by 1.
- Terminal event: match_o[n]=1 for that cycle (registered, asserted the cycle after the terminal edge) and STATUS.match set.
- Out-of-range count: count > LIMIT in up mode counts on and wraps through all ones to 0. No terminal event until it reaches LIMIT.
- Simultaneous events:
  - Bus write to COUNT wins over a tick in the same cycle; that tick is lost and the prescaler still restarts.
  - STATUS W1C in the same cycle as a new terminal event leaves match=1 (set wins).
  - Writing CTRL with en=0 takes effect immediately; no tick on that edge.
  - Writing LIMIT mid-run takes effect from the next comparison.
- Reset asserted mid-count or mid-transaction returns all state to reset values on that edge. ready drops, and a pending access is discarded.
- irq is combinational from registered state; no extra latency.

Test Plan:
- Reset, then read CTRL/COUNT/LIMIT/STATUS of ch0 -> 0x0, 0x0, 0xFFFFFFFF, 0x0. Each access acks with exactly one ready pulse one cycle after valid.
- ch1: LIMIT=3, CTRL=0x1 (up, presc 0, auto-reload) -> count_o ch1 runs 0,1,2,3,0,1… ; match_o[1] pulses once per 4 cycles; STATUS.match=1.
- ch2: LIMIT=5, COUNT=5, CTRL=0x0207 (down, oneshot, presc 2) -> count decrements every 3 cycles to 0. Then one match_o[2] pulse, CTRL.en reads 0, count stays 0.
- ch0: irq_en set, match pending -> irq=1. W1C on STATUS in the same cycle as the next terminal event -> STATUS stays 1. A later W1C with no event -> STATUS 0, irq 0.
- Byte write COUNT ch3 with wstrb=0010, wdata=0x0000AB00, while running with a tick coincident -> only byte1 becomes 0xAB, other bytes keep their pre-write values, tick lost. Write to channel 7 with NUM_CH=4 -> acked, no state change, reads 0.
- Assert wb_rst_i for 1 cycle while ch1 is counting and valid is high -> all counters 0, en 0, ready 0 on the next cycle; the bus retry completes normally.
